// File: rtl/fe_map_feeder_if.sv
// Handshake bundle between the pixel/map feeder and its neighbours: frame control,
// raster pixel input, and the packed map-word output toward FeatureExtraction.
interface fe_map_feeder_if #(
    parameter int PIX_W       = 8,
    parameter int WORD_PIXELS = 16
);
    logic                         frame_go;
    logic [PIX_W-1:0]             pix_in;
    logic                         pix_valid;
    logic                         pix_ready;
    logic [PIX_W*WORD_PIXELS-1:0] map_out;
    logic                         start;
    logic                         ready;
    logic                         busy;
    logic                         frame_done;

    modport master (
        input  frame_go, pix_in, pix_valid, ready,
        output pix_ready, map_out, start, busy, frame_done
    );

    modport slave (
        output frame_go, pix_in, pix_valid, ready,
        input  pix_ready, map_out, start, busy, frame_done
    );
endinterface

// File: rtl/fe_map_feeder.sv
// Walks the zero-padded frame in raster order, packs one pixel per cycle into a
// map word, and hands finished words over a start/ready output register.
module fe_map_feeder #(
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int PAD         = 2,
    parameter int PIX_W       = 8,
    parameter int WORD_PIXELS = 16
) (
    input  logic           clk_in,
    input  logic           rst_in,
    fe_map_feeder_if.master bus
);
    localparam int PW     = IMG_W + 2 * PAD;
    localparam int PH     = IMG_H + 2 * PAD;
    localparam int RW     = $clog2(PH + 1);
    localparam int CW     = $clog2(PW + 1);
    localparam int LW     = $clog2(WORD_PIXELS);
    localparam int WORD_W = WORD_PIXELS * PIX_W;

    localparam logic [RW-1:0] ROW_LO    = RW'(PAD);
    localparam logic [RW-1:0] ROW_HI    = RW'(PAD + IMG_H);
    localparam logic [RW-1:0] ROW_LAST  = RW'(PH - 1);
    localparam logic [CW-1:0] COL_LO    = CW'(PAD);
    localparam logic [CW-1:0] COL_HI    = CW'(PAD + IMG_W);
    localparam logic [CW-1:0] COL_LAST  = CW'(PW - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(WORD_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DRAIN
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [LW-1:0]     lane;
    logic [WORD_W-1:0] pack_q;
    logic [WORD_W-1:0] pack_next;
    logic [WORD_W-1:0] out_q;
    logic              start_q;
    logic              done_q;

    logic              is_pad;
    logic              is_last;
    logic              out_xfer;
    logic              out_free;
    logic              lane_last;
    logic              stall;
    logic              write_en;
    logic              fill_pix_ready;
    logic [PIX_W-1:0]  lane_data;

    assign is_pad    = (row < ROW_LO) || (row >= ROW_HI) || (col < COL_LO) || (col >= COL_HI);
    assign is_last   = (row == ROW_LAST) && (col == COL_LAST);
    assign out_xfer  = start_q && bus.ready;
    assign out_free  = !start_q || out_xfer;
    assign lane_last = (lane == LANE_LAST);
    // Completing a word needs a free output slot; otherwise everything freezes.
    assign stall     = lane_last && !out_free;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        write_en       = 1'b0;
        fill_pix_ready = 1'b0;
        lane_data      = '0;
        case (state)
            IDLE: begin
                if (bus.frame_go) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (!stall) begin
                    if (is_pad) begin
                        write_en = 1'b1;
                    end else begin
                        fill_pix_ready = 1'b1;
                        write_en       = bus.pix_valid;
                        lane_data      = bus.pix_in;
                    end
                    if (write_en && is_last) begin
                        next_state = lane_last ? DRAIN : FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    write_en = 1'b1;
                    if (lane_last) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pack_next = pack_q;
        pack_next[lane*PIX_W +: PIX_W] = lane_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row     <= '0;
            col     <= '0;
            lane    <= '0;
            pack_q  <= '0;
            out_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && out_xfer;
            if (state == IDLE && bus.frame_go) begin
                row  <= '0;
                col  <= '0;
                lane <= '0;
            end
            if (write_en) begin
                pack_q <= pack_next;
                lane   <= lane_last ? '0 : lane + LW'(1);
                if (state == FILL) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
            // A freshly completed word takes priority, so back-to-back words leave no bubble.
            if (write_en && lane_last) begin
                out_q   <= pack_next;
                start_q <= 1'b1;
            end else if (out_xfer) begin
                start_q <= 1'b0;
            end
        end
    end

    assign bus.pix_ready  = fill_pix_ready;
    assign bus.map_out    = out_q;
    assign bus.start      = start_q;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_fe_map_feeder.sv
// Bench for fe_map_feeder: scenario table on a default 32x32 instance plus a 3x3
// instance for the flushed tail, all words checked against a padded-frame model.
module tb_fe_map_feeder;
    typedef logic [127:0] word_t;

    typedef struct {
        string name;
        bit    rand_valid;
        bit    rand_ready;
        int    bp;
        bit    mid_go;
        int    exp_words;
        int    exp_pix;
    } scen_t;

    typedef struct {
        string name;
        bit    tail;
        int    word;
        word_t exp;
    } spot_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fe_map_feeder_if #(.PIX_W(8), .WORD_PIXELS(16)) bus_a ();
    fe_map_feeder_if #(.PIX_W(8), .WORD_PIXELS(16)) bus_b ();

    fe_map_feeder #(.IMG_W(32), .IMG_H(32), .PAD(2), .PIX_W(8), .WORD_PIXELS(16)) dut_a (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_a.master)
    );

    fe_map_feeder #(.IMG_W(3), .IMG_H(3), .PAD(2), .PIX_W(8), .WORD_PIXELS(16)) dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_b.master)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int go_cyc;

    word_t got_a[$];
    word_t got_b[$];
    int consumed_a, consumed_b;
    int done_a, done_b, done_cyc_a, done_cyc_b;
    int last_xfer_a, last_xfer_b;
    int first_busy_a, first_start_a;
    int hold_err, stallpr_err, done_busy_err;
    int stall_run, max_stall;
    bit took_a, took_b;
    int idx_a, idx_b;
    bit prev_start, prev_xfer;
    word_t prev_map;
    bit rand_valid, rand_ready, bp_pending;
    int bp_cycles, bp_left;

    scen_t scens[5];
    spot_t spots[6];

    // Padded-frame reference: word n holds positions n*16..n*16+15, image pixels numbered from 1.
    function automatic word_t modelWord(input int w, input int h, input int pad, input int n);
        word_t wd;
        int pw, ph, p, r, c;
        pw = w + 2 * pad;
        ph = h + 2 * pad;
        wd = '0;
        for (int l = 0; l < 16; l++) begin
            p = n * 16 + l;
            if (p < pw * ph) begin
                r = p / pw;
                c = p % pw;
                if (r >= pad && r < pad + h && c >= pad && c < pad + w)
                    wd[l*8 +: 8] = 8'((r - pad) * w + (c - pad) + 1);
            end
        end
        return wd;
    endfunction

    task automatic checkOutput(input string name, input word_t act, input word_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic resetMonitors();
        got_a.delete();
        got_b.delete();
        consumed_a = 0; consumed_b = 0;
        done_a = 0; done_b = 0; done_cyc_a = -1; done_cyc_b = -1;
        last_xfer_a = -1; last_xfer_b = -1;
        first_busy_a = -1; first_start_a = -1;
        hold_err = 0; stallpr_err = 0; done_busy_err = 0;
        stall_run = 0; max_stall = 0;
        prev_start = 0; prev_xfer = 0; prev_map = '0;
        idx_a = 0; idx_b = 0;
        bp_pending = 0; bp_left = 0;
    endtask

    task automatic sampleOutputs();
        took_a = bus_a.pix_valid && bus_a.pix_ready;
        if (took_a) consumed_a++;
        if (bus_a.busy && first_busy_a < 0) first_busy_a = cyc;
        if (bus_a.start && first_start_a < 0) first_start_a = cyc;
        if (prev_start && !prev_xfer && (!bus_a.start || bus_a.map_out !== prev_map)) hold_err++;
        prev_start = bus_a.start;
        prev_xfer  = bus_a.start && bus_a.ready;
        prev_map   = bus_a.map_out;
        if (prev_xfer) begin
            got_a.push_back(bus_a.map_out);
            last_xfer_a = cyc;
        end
        if (bus_a.start && !bus_a.ready) begin
            stall_run++;
            if (stall_run > max_stall) max_stall = stall_run;
            if (stall_run >= 17 && bus_a.pix_ready) stallpr_err++;
        end else begin
            stall_run = 0;
        end
        if (bus_a.frame_done) begin
            done_a++;
            done_cyc_a = cyc;
            if (bus_a.busy) done_busy_err++;
        end
        took_b = bus_b.pix_valid && bus_b.pix_ready;
        if (took_b) consumed_b++;
        if (bus_b.start && bus_b.ready) begin
            got_b.push_back(bus_b.map_out);
            last_xfer_b = cyc;
        end
        if (bus_b.frame_done) begin
            done_b++;
            done_cyc_b = cyc;
        end
    endtask

    task automatic driveInputs();
        if (took_a) idx_a++;
        bus_a.pix_in    = 8'(idx_a + 1);
        bus_a.pix_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bp_pending && bus_a.start) begin
            bp_left    = bp_cycles;
            bp_pending = 0;
        end
        if (bp_left > 0) begin
            bus_a.ready = 1'b0;
            bp_left--;
        end else begin
            bus_a.ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (took_b) idx_b++;
        bus_b.pix_in    = 8'(idx_b + 1);
        bus_b.pix_valid = 1'b1;
        bus_b.ready     = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        cyc++;
        #1;
        driveInputs();
    endtask

    task automatic applyStimulus(input scen_t s);
        resetMonitors();
        rand_valid = s.rand_valid;
        rand_ready = s.rand_ready;
        bp_cycles  = s.bp;
        bp_pending = (s.bp > 0);
        bus_a.pix_in = 8'd1;
        go_cyc = cyc;
        bus_a.frame_go = 1'b1;
        tick();
        for (int i = 0; i < 8000 && done_a == 0; i++) begin
            bus_a.frame_go = (s.mid_go && cyc == go_cyc + 200);
            tick();
        end
        bus_a.frame_go = 1'b0;
        repeat (5) tick();
        rand_valid = 0;
        rand_ready = 0;
    endtask

    task automatic checkFrame(input scen_t s);
        int bad;
        bad = -1;
        checkOutput({s.name, " word count"}, got_a.size(), s.exp_words);
        checkOutput({s.name, " pixels consumed"}, consumed_a, s.exp_pix);
        for (int i = 0; i < got_a.size(); i++)
            if (bad < 0 && got_a[i] !== modelWord(32, 32, 2, i)) bad = i;
        checks++;
        if (bad < 0) passes++;
        else $display("[TB] FAIL %s word sequence: word %0d got 0x%0h, expected 0x%0h",
                      s.name, bad, got_a[bad], modelWord(32, 32, 2, bad));
        checkOutput({s.name, " frame_done count"}, done_a, 1);
        checkOutput({s.name, " frame_done cycle"}, done_cyc_a, last_xfer_a + 1);
        checkOutput({s.name, " busy rise cycle"}, first_busy_a, go_cyc + 1);
        checkOutput({s.name, " first start cycle"}, first_start_a, go_cyc + 17);
        checkOutput({s.name, " map_out hold violations"}, hold_err, 0);
        checkOutput({s.name, " busy on frame_done"}, done_busy_err, 0);
        if (s.bp > 0) begin
            checkOutput({s.name, " stall length"}, max_stall, s.bp);
            checkOutput({s.name, " pix_ready while stalled"}, stallpr_err, 0);
        end
    endtask

    initial begin
        int bad_b;
        word_t act;

        scens[0] = '{"nominal",      1'b0, 1'b0, 0,  1'b0, 81, 1024};
        scens[1] = '{"backpressure", 1'b0, 1'b0, 20, 1'b0, 81, 1024};
        scens[2] = '{"input gaps",   1'b1, 1'b0, 0,  1'b0, 81, 1024};
        scens[3] = '{"gaps+ready",   1'b1, 1'b1, 0,  1'b0, 81, 1024};
        scens[4] = '{"go in FILL",   1'b0, 1'b0, 0,  1'b1, 81, 1024};

        spots[0] = '{"nominal word 0",  1'b0, 0, 128'h0};
        spots[1] = '{"nominal word 4",  1'b0, 4, 128'h0605_0403_0201_0000_0000_0000_0000_0000};
        spots[2] = '{"tail word 0",     1'b1, 0, 128'h0};
        spots[3] = '{"tail word 1",     1'b1, 1, 128'h0807_0000_0000_0605_0400_0000_0003_0201};
        spots[4] = '{"tail word 2",     1'b1, 2, 128'h0000_0000_0000_0000_0000_0000_0000_0009};
        spots[5] = '{"tail word 3",     1'b1, 3, 128'h0};

        rst = 1'b1;
        bus_a.frame_go = 1'b0; bus_a.pix_in = '0; bus_a.pix_valid = 1'b0; bus_a.ready = 1'b1;
        bus_b.frame_go = 1'b0; bus_b.pix_in = '0; bus_b.pix_valid = 1'b0; bus_b.ready = 1'b1;
        rand_valid = 0; rand_ready = 0; bp_cycles = 0;
        resetMonitors();
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("reset map_out", bus_a.map_out, 0);
        checkOutput("reset start", bus_a.start, 0);
        checkOutput("reset pix_ready", bus_a.pix_ready, 0);
        checkOutput("reset busy", bus_a.busy, 0);
        checkOutput("reset frame_done", bus_a.frame_done, 0);
        tick();

        for (int i = 0; i < 5; i++) begin
            $display("[TB] scenario %s", scens[i].name);
            applyStimulus(scens[i]);
            checkFrame(scens[i]);
        end

        $display("[TB] reset at word 40");
        resetMonitors();
        bus_a.frame_go = 1'b1;
        tick();
        bus_a.frame_go = 1'b0;
        for (int i = 0; i < 2000 && got_a.size() < 40; i++) tick();
        checkOutput("words before mid-frame reset", got_a.size(), 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid reset map_out", bus_a.map_out, 0);
        checkOutput("mid reset start", bus_a.start, 0);
        checkOutput("mid reset pix_ready", bus_a.pix_ready, 0);
        checkOutput("mid reset busy", bus_a.busy, 0);
        checkOutput("mid reset frame_done", bus_a.frame_done, 0);
        repeat (20) tick();
        checkOutput("no frame_done after reset", done_a, 0);
        checkOutput("idle after reset", bus_a.busy, 0);

        applyStimulus(scens[0]);
        checkFrame('{"after reset", 1'b0, 1'b0, 0, 1'b0, 81, 1024});

        $display("[TB] partial tail frame");
        bus_b.frame_go = 1'b1;
        tick();
        bus_b.frame_go = 1'b0;
        for (int i = 0; i < 500 && done_b == 0; i++) tick();
        repeat (5) tick();
        checkOutput("tail word count", got_b.size(), 4);
        checkOutput("tail pixels consumed", consumed_b, 9);
        checkOutput("tail frame_done count", done_b, 1);
        checkOutput("tail frame_done cycle", done_cyc_b, last_xfer_b + 1);
        bad_b = -1;
        for (int i = 0; i < got_b.size(); i++)
            if (bad_b < 0 && got_b[i] !== modelWord(3, 3, 2, i)) bad_b = i;
        checks++;
        if (bad_b < 0) passes++;
        else $display("[TB] FAIL tail word sequence: word %0d got 0x%0h, expected 0x%0h",
                      bad_b, got_b[bad_b], modelWord(3, 3, 2, bad_b));

        for (int i = 0; i < 6; i++) begin
            act = 'x;
            if (spots[i].tail) begin
                if (spots[i].word < got_b.size()) act = got_b[spots[i].word];
            end else begin
                if (spots[i].word < got_a.size()) act = got_a[spots[i].word];
            end
            checkOutput(spots[i].name, act, spots[i].exp);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
